// File: rtl/ahb_lite_slave_mem.sv
// AHB-Lite slave memory: pipelined address/data phases, byte-lane write strobes, two-cycle ERROR response.
// Latency: zero-wait OKAY when WAIT_STATES=0, else WAIT_STATES low-HREADYOUT cycles per data phase; errors take two cycles.
// Backpressure: HREADYOUT low stalls the master in WAIT and ERR1; the next address phase is sampled only while HREADYOUT is high.
module ahb_lite_slave_mem #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  output logic [DATA_WIDTH-1:0] HRDATA,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [2:0]            HBURST,
  input  logic [3:0]            HPROT,
  input  logic [1:0]            HTRANS,
  input  logic                  HMASTERLOCK,
  input  logic                  HREADYIN,
  output logic                  HREADYOUT,
  output logic                  HRESP
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int LANE_BITS = $clog2(BYTES);
  localparam int IDX_BITS  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int OFF_BITS  = LANE_BITS + IDX_BITS;

  // One bit wider than HADDR so the range compare cannot wrap.
  localparam logic [ADDR_WIDTH:0] MEM_BYTES = (ADDR_WIDTH + 1)'(MEM_DEPTH * BYTES);

  // Counter reload gives exactly WAIT_STATES cycles in WAIT (counts down to 0 inclusive).
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [2:0] {
    st_idle,
    st_wait,
    st_data,
    st_err1,
    st_err2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic                 accept;
  logic                 size_bad;
  logic                 misalign;
  logic                 range_bad;
  logic                 xfer_err;
  logic [LANE_BITS-1:0] lane_mask;

  logic [OFF_BITS-1:0]  addr_q;
  logic                 write_q;
  logic [2:0]           size_q;
  logic [3:0]           wait_cnt;

  logic [IDX_BITS-1:0]  mem_idx;
  logic [LANE_BITS-1:0] lane_q;
  logic [BYTES-1:0]     byte_en;
  logic                 mem_we;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Burst type, protection, lock and the SEQ/NONSEQ distinction do not change how a beat is served.
  logic unused_inputs;
  assign unused_inputs = ^{HBURST, HPROT, HMASTERLOCK, HTRANS[0]};

  // A new address phase is taken only while this slave is presenting ready.
  assign accept = HREADYOUT & HSEL & HREADYIN & HTRANS[1];

  // Classify the transfer currently on the address bus: too wide, misaligned, or beyond the array.
  always_comb begin
    lane_mask = ~({LANE_BITS{1'b1}} << HSIZE);
    size_bad  = (HSIZE > 3'(LANE_BITS));
    misalign  = |(HADDR[LANE_BITS-1:0] & lane_mask);
    range_bad = ({1'b0, HADDR} >= MEM_BYTES);
    xfer_err  = size_bad | misalign | range_bad;
  end

  // State register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= st_idle;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; every ready state evaluates a new address phase on the same edge.
  always_comb begin
    state_nxt = state;
    case (state)
      st_idle, st_data, st_err2: begin
        if (accept) begin
          if (xfer_err) begin
            state_nxt = st_err1;
          end else if (WAIT_STATES > 0) begin
            state_nxt = st_wait;
          end else begin
            state_nxt = st_data;
          end
        end else begin
          state_nxt = st_idle;
        end
      end
      st_wait: begin
        if (wait_cnt == 4'd0) begin
          state_nxt = st_data;
        end
      end
      st_err1: state_nxt = st_err2;
      default: state_nxt = st_idle;
    endcase
  end

  // Output decode: ready and response are pure functions of state; read data only in WAIT/DATA.
  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    HRDATA    = '0;
    case (state)
      st_wait: begin
        HREADYOUT = 1'b0;
        HRDATA    = mem[mem_idx];
      end
      st_data: begin
        HRDATA    = mem[mem_idx];
      end
      st_err1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      st_err2: begin
        HRESP     = 1'b1;
      end
      default: begin
        HREADYOUT = 1'b1;
      end
    endcase
  end

  // Address-phase capture and wait-state countdown.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_q   <= '0;
      write_q  <= 1'b0;
      size_q   <= 3'd0;
      wait_cnt <= 4'd0;
    end else if (accept) begin
      addr_q   <= HADDR[OFF_BITS-1:0];
      write_q  <= HWRITE;
      size_q   <= HSIZE;
      wait_cnt <= WAIT_LOAD;
    end else if (state == st_wait && wait_cnt != 4'd0) begin
      wait_cnt <= wait_cnt - 4'd1;
    end
  end

  assign mem_idx = addr_q[OFF_BITS-1:LANE_BITS];
  assign lane_q  = addr_q[LANE_BITS-1:0];

  // Byte lanes that fall in the same size-aligned block as the latched offset (little-endian).
  always_comb begin
    byte_en = '0;
    for (int b = 0; b < BYTES; b++) begin
      byte_en[b] = ((b >> size_q) == (int'(lane_q) >> size_q));
    end
  end

  // Write commits on the edge that closes DATA; a reset on that edge discards it.
  assign mem_we = (state == st_data) && write_q && !HRESET;

  // Memory array, strobed per byte lane; contents deliberately survive reset.
  always_ff @(posedge HCLK) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (byte_en[b]) begin
          mem[mem_idx][8*b +: 8] <= HWDATA[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_slave_mem.sv
// Bench for ahb_lite_slave_mem: three instances (0, 2, 3 wait states) share one AHB master model.
// Latency: each beat's expected response is queued at its address phase and compared when its data phase ends.
// Backpressure: the master holds the address phase while the selected slave drives HREADYOUT low.
module tb_ahb_lite_slave_mem;

  localparam int AW = 32;
  localparam int DW = 32;

  localparam logic [1:0] T_IDLE = 2'd0;
  localparam logic [1:0] T_BUSY = 2'd1;
  localparam logic [1:0] T_NSEQ = 2'd2;
  localparam logic [1:0] T_SEQ  = 2'd3;

  logic          HCLK = 1'b0;
  logic          HRESET;
  logic          hsel;
  logic [AW-1:0] HADDR;
  logic [DW-1:0] HWDATA;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic [2:0]    HBURST;
  logic [3:0]    HPROT;
  logic [1:0]    HTRANS;
  logic          HMASTERLOCK;
  logic          HREADYIN;

  logic [DW-1:0] rdata_d [3];
  logic          rdy_d   [3];
  logic          resp_d  [3];

  int            cur;
  logic [DW-1:0] rdata;
  logic          rdy;
  logic          resp;

  int checks   = 0;
  int failures = 0;

  always #5 HCLK = ~HCLK;

  ahb_lite_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(256), .WAIT_STATES(0)) u_ws0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel && cur == 0), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(rdata_d[0]), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTERLOCK(HMASTERLOCK), .HREADYIN(HREADYIN),
    .HREADYOUT(rdy_d[0]), .HRESP(resp_d[0]));

  ahb_lite_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(256), .WAIT_STATES(2)) u_ws2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel && cur == 1), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(rdata_d[1]), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTERLOCK(HMASTERLOCK), .HREADYIN(HREADYIN),
    .HREADYOUT(rdy_d[1]), .HRESP(resp_d[1]));

  ahb_lite_slave_mem #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_DEPTH(256), .WAIT_STATES(3)) u_ws3 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel && cur == 2), .HADDR(HADDR), .HWDATA(HWDATA),
    .HRDATA(rdata_d[2]), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
    .HTRANS(HTRANS), .HMASTERLOCK(HMASTERLOCK), .HREADYIN(HREADYIN),
    .HREADYOUT(rdy_d[2]), .HRESP(resp_d[2]));

  // Bus return path from the currently addressed slave.
  always_comb begin
    rdata = rdata_d[0];
    rdy   = rdy_d[0];
    resp  = resp_d[0];
    if (cur == 1) begin
      rdata = rdata_d[1];
      rdy   = rdy_d[1];
      resp  = resp_d[1];
    end else if (cur == 2) begin
      rdata = rdata_d[2];
      rdy   = rdy_d[2];
      resp  = resp_d[2];
    end
  end

  assign HREADYIN = rdy;

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic        chk_rd;
  } vec_t;

  typedef struct {
    int          beat;
    logic        err;
    logic [31:0] rdata;
    logic        chk_rd;
    logic [31:0] wdata;
    int          waits;
  } exp_t;

  vec_t  vec [$];
  string test_name;

  function automatic int ws_of(input int k);
    if (k == 1) return 2;
    if (k == 2) return 3;
    return 0;
  endfunction

  function automatic void add(input logic [1:0] t, input logic w, input logic [2:0] s,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic e, input logic [31:0] r);
    vec_t v;
    v.trans  = t;
    v.wr     = w;
    v.size   = s;
    v.addr   = a;
    v.wdata  = d;
    v.err    = e;
    v.rdata  = r;
    v.chk_rd = !w || e || !t[1];
    vec.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s %s: got %h expected %h", test_name, name, act, exp);
    end
  endtask

  task automatic bus_idle();
    hsel   = 1'b0;
    HTRANS = T_IDLE;
    HADDR  = '0;
    HWRITE = 1'b0;
    HSIZE  = 3'd0;
  endtask

  // Plays the vector table as a pipelined master and scores each data phase against the queue.
  task automatic run_seq();
    exp_t sb [$];
    exp_t e;
    int   ai = 0;
    int   n = vec.size();
    int   cyc = 0;
    int   waits = 0;
    while ((ai < n || sb.size() != 0) && cyc < 300) begin
      if (ai < n) begin
        hsel   = 1'b1;
        HTRANS = vec[ai].trans;
        HADDR  = vec[ai].addr;
        HWRITE = vec[ai].wr;
        HSIZE  = vec[ai].size;
      end else begin
        bus_idle();
      end
      HWDATA = (sb.size() != 0) ? sb[0].wdata : '0;
      @(negedge HCLK);
      if (sb.size() != 0) begin
        if (rdy) begin
          e = sb.pop_front();
          chk($sformatf("beat%0d resp", e.beat), 64'(resp), 64'(e.err));
          chk($sformatf("beat%0d waits", e.beat), 64'(waits), 64'(e.waits));
          if (e.chk_rd) chk($sformatf("beat%0d rdata", e.beat), 64'(rdata), 64'(e.rdata));
          waits = 0;
        end else begin
          waits++;
          chk($sformatf("beat%0d stall resp", sb[0].beat), 64'(resp), 64'(sb[0].err));
        end
      end
      if (rdy && ai < n) begin
        e.beat   = ai;
        e.err    = vec[ai].err;
        e.rdata  = vec[ai].err ? 32'h0 : vec[ai].rdata;
        e.chk_rd = vec[ai].chk_rd;
        e.wdata  = vec[ai].wdata;
        e.waits  = !vec[ai].trans[1] ? 0 : (vec[ai].err ? 1 : ws_of(cur));
        sb.push_back(e);
        ai++;
      end
      @(posedge HCLK);
      #1;
      cyc++;
    end
    if (cyc >= 300) begin
      checks++;
      failures++;
      $display("FAIL %s timeout: got %0d cycles expected completion", test_name, cyc);
    end
    vec.delete();
    bus_idle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cur         = 0;
    HRESET      = 1'b1;
    HWDATA      = '0;
    HBURST      = 3'd0;
    HPROT       = 4'h3;
    HMASTERLOCK = 1'b0;
    bus_idle();

    // Reset state of every instance.
    test_name = "reset";
    repeat (2) @(posedge HCLK);
    @(negedge HCLK);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("dut%0d hreadyout", k), 64'(rdy_d[k]), 64'd1);
      chk($sformatf("dut%0d hresp", k), 64'(resp_d[k]), 64'd0);
      chk($sformatf("dut%0d hrdata", k), 64'(rdata_d[k]), 64'd0);
    end
    HRESET = 1'b0;
    @(posedge HCLK);
    #1;

    // Back-to-back write then read, no wait states.
    test_name = "raw_ws0";
    cur = 0;
    add(T_NSEQ, 1, 3'd2, 32'h10, 32'hDEADBEEF, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 32'h10, 32'h0, 0, 32'hDEADBEEF);
    add(T_IDLE, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0);
    run_seq();

    // Wait-state insertion with three wait cycles.
    test_name = "ws3";
    cur = 2;
    add(T_NSEQ, 1, 3'd2, 32'h20, 32'h0BADF00D, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 32'h20, 32'h0, 0, 32'h0BADF00D);
    run_seq();

    // Byte and halfword strobing; junk in unselected lanes must not land.
    test_name = "strobe";
    cur = 0;
    add(T_NSEQ, 1, 3'd0, 32'h40, 32'hEEEEEE11, 0, 32'h0);
    add(T_NSEQ, 1, 3'd0, 32'h41, 32'hEEEE22EE, 0, 32'h0);
    add(T_NSEQ, 1, 3'd1, 32'h42, 32'h4433EEEE, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 32'h40, 32'h0, 0, 32'h44332211);
    add(T_NSEQ, 1, 3'd0, 32'h43, 32'h99777777, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 32'h40, 32'h0, 0, 32'h99332211);
    add(T_NSEQ, 1, 3'd1, 32'h40, 32'h55556666, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 32'h40, 32'h0, 0, 32'h99336666);
    run_seq();

    // Error responses: range, misalignment, oversize; memory must be untouched.
    test_name = "error";
    cur = 0;
    add(T_NSEQ, 1, 3'd2, 32'h0,   32'hA5A5A5A5, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 32'h400, 32'h0,        1, 32'h0);
    add(T_NSEQ, 1, 3'd2, 32'h400, 32'hFFFFFFFF, 1, 32'h0);
    add(T_NSEQ, 0, 3'd2, 32'h02,  32'h0,        1, 32'h0);
    add(T_NSEQ, 1, 3'd2, 32'h02,  32'hFFFFFFFF, 1, 32'h0);
    add(T_NSEQ, 1, 3'd1, 32'h01,  32'hFFFFFFFF, 1, 32'h0);
    add(T_NSEQ, 0, 3'd3, 32'h08,  32'h0,        1, 32'h0);
    add(T_NSEQ, 0, 3'd2, 32'h0,   32'h0,        0, 32'hA5A5A5A5);
    add(T_NSEQ, 1, 3'd2, 32'h3FC, 32'h13579BDF, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 32'h3FC, 32'h0,        0, 32'h13579BDF);
    run_seq();

    // INCR4 with a BUSY beat on the 3-wait-state slave: BUSY must be zero-wait and write nothing.
    test_name = "burst";
    cur = 2;
    add(T_NSEQ, 1, 3'd2, 32'h80, 32'h1, 0, 32'h0);
    add(T_SEQ,  1, 3'd2, 32'h84, 32'h2, 0, 32'h0);
    add(T_BUSY, 1, 3'd2, 32'h88, 32'hBAD0BAD0, 0, 32'h0);
    add(T_SEQ,  1, 3'd2, 32'h88, 32'h3, 0, 32'h0);
    add(T_SEQ,  1, 3'd2, 32'h8C, 32'h4, 0, 32'h0);
    add(T_NSEQ, 0, 3'd2, 32'h80, 32'h0, 0, 32'h1);
    add(T_SEQ,  0, 3'd2, 32'h84, 32'h0, 0, 32'h2);
    add(T_SEQ,  0, 3'd2, 32'h88, 32'h0, 0, 32'h3);
    add(T_SEQ,  0, 3'd2, 32'h8C, 32'h0, 0, 32'h4);
    run_seq();

    // Reset in the first wait cycle aborts the write.
    test_name = "reset_abort";
    cur = 1;
    add(T_NSEQ, 1, 3'd2, 32'h50, 32'h0, 0, 32'h0);
    run_seq();
    hsel   = 1'b1;
    HTRANS = T_NSEQ;
    HADDR  = 32'h50;
    HWRITE = 1'b1;
    HSIZE  = 3'd2;
    @(negedge HCLK);
    chk("addr phase hreadyout", 64'(rdy), 64'd1);
    @(posedge HCLK);
    #1;
    bus_idle();
    HWDATA = 32'hCAFEF00D;
    @(negedge HCLK);
    chk("first wait hreadyout", 64'(rdy), 64'd0);
    HRESET = 1'b1;
    @(posedge HCLK);
    #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("post reset hreadyout", 64'(rdy), 64'd1);
    chk("post reset hresp", 64'(resp), 64'd0);
    chk("post reset hrdata", 64'(rdata), 64'd0);
    repeat (4) @(posedge HCLK);
    #1;
    add(T_NSEQ, 0, 3'd2, 32'h50, 32'h0, 0, 32'h0);
    run_seq();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_lite_slave_mem.md
Name: ahb_lite_slave_mem

Overview:
Parametrised AHB-Lite slave memory that terminates one ahb_intf-style slave port. It adds the following on top of the plain signal bundle:
- a real address/data-phase pipeline;
- byte/halfword/word write strobing;
- configurable wait-state insertion;
- the two-cycle ERROR response.

It is used as the default target memory behind the bus fabric and as the reference slave for the UVM AHB agent.

Parameters:
- ADDR_WIDTH, 32, HADDR width in bits.
- DATA_WIDTH, 32, HWDATA/HRDATA width; legal values 32 or 64.
- MEM_DEPTH, 256, number of DATA_WIDTH-bit words; the byte size is MEM_DEPTH*DATA_WIDTH/8.
- WAIT_STATES, 0, number of HREADYOUT=0 cycles inserted before every OKAY data phase completes; range 0..15.

Ports:
- HCLK, in, 1, bus clock; all logic on its rising edge.
- HRESET, in, 1, synchronous active-high reset.
- HSEL, in, 1, slave select.
- HADDR, in, ADDR_WIDTH, byte address.
- HWDATA, in, DATA_WIDTH, write data (data phase).
- HRDATA, out, DATA_WIDTH, read data (data phase).
- HWRITE, in, 1, 1 = write.
- HSIZE, in, 3, transfer size (0 = byte, 1 = half, 2 = word, 3 = dword).
- HBURST, in, 3, accepted but ignored; each beat is handled individually.
- HPROT, in, 4, accepted but ignored.
- HTRANS, in, 2, 0 = IDLE, 1 = BUSY, 2 = NONSEQ, 3 = SEQ.
- HMASTERLOCK, in, 1, accepted but ignored.
- HREADYIN, in, 1, bus ready; qualifies the address phase.
- HREADYOUT, out, 1, slave ready.
- HRESP, out, 1, 0 = OKAY, 1 = ERROR.

Behaviour:
- States: IDLE, WAIT, DATA, ERR1, ERR2.
  - HREADYOUT = 1 in IDLE, DATA and ERR2; 0 in WAIT and ERR1.
  - HRESP = 1 only in ERR1 and ERR2.
- Address-phase acceptance: on any edge where HREADYOUT=1 and HSEL & HREADYIN & HTRANS[1], latch HADDR, HWRITE and HSIZE.
  - IDLE or BUSY transfers, or no HSEL, give the next state IDLE: zero-wait OKAY, nothing latched.
- Error check on the accepted transfer:
  - The transfer is an error if any of these holds: 8<<HSIZE > DATA_WIDTH; HADDR not aligned to its size; HADDR >= MEM_DEPTH*DATA_WIDTH/8.
  - Error path: next state ERR1, then ERR2 unconditionally.
  - No memory access on an error; HRDATA = 0.
- Legal transfer:
  - Next state is WAIT if WAIT_STATES > 0, otherwise DATA.
  - The wait counter loads WAIT_STATES-1, decrements in WAIT, and moves to DATA when it reaches 0.
  - Exactly WAIT_STATES low cycles precede the ready cycle.
- DATA, ERR2 and IDLE all evaluate a new address phase on the same edge (back-to-back pipelining; no dead cycle).
- Write:
  - HWDATA is sampled on the edge that ends the DATA state.
  - Only the byte lanes selected by HSIZE and the low HADDR bits are written; little-endian lane mapping.
- Read:
  - HRDATA is combinational from the memory word at the latched address, during WAIT and DATA.
  - HRDATA = 0 in IDLE, ERR1 and ERR2.
  - The full word is returned; the master selects lanes.
- Read-after-write to the same address in consecutive transfers returns the new data; the write commits before the read's data phase.
- Reset:
  - Outputs HREADYOUT=1, HRESP=0, HRDATA=0; state IDLE; wait counter 0.
  - Reset asserted mid-transfer (in WAIT or DATA) aborts the transfer and no write commits.
  - Memory contents are not reset; a read of an unwritten location is X.
- The HTRANS/HADDR value presented during ERR1 is ignored. The master may cancel to IDLE in ERR1, or present any transfer there; neither is latched.

Test Plan:
1. WAIT_STATES=0: NONSEQ word write 0xDEADBEEF @0x10, then NONSEQ read @0x10 back-to-back -> HREADYOUT stays 1 throughout; read data phase HRDATA=0xDEADBEEF, HRESP=0.
2. WAIT_STATES=3: word read @0x20 -> HREADYOUT low for exactly 3 cycles, then high with valid HRDATA; HRESP=0 throughout.
3. Byte writes 0x11 @0x40, 0x22 @0x41, halfword 0x4433 @0x42; then word read @0x40 -> HRDATA=0x44332211.
4. Read @0x400 with MEM_DEPTH=256, DATA_WIDTH=32 -> ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1); memory unchanged. Repeat with misaligned word @0x02 and with HSIZE=3 -> same ERROR sequence.
5. Burst INCR4 (NONSEQ, SEQ, BUSY, SEQ, SEQ) writing 1..4 @0x80 -> BUSY cycle gets zero-wait OKAY with no write; read back 0x80..0x8C = 1,2,3,4.
6. WAIT_STATES=2: write 0xCAFEF00D @0x50 with HRESET asserted in its first wait cycle -> next cycle HREADYOUT=1, HRESP=0; a later read @0x50 does not return 0xCAFEF00D (pre-load 0x0 first).
